// File: rtl/ptn_pkg.sv
// Shared constants for the VGA test-pattern scheduler: pattern indices,
// default pattern count, field widths and FSM state encoding.
package ptn_pkg;

  localparam int unsigned NUM_PTN_DEF = 4;
  localparam int unsigned PTN_W       = 3;
  localparam int unsigned CNT_W       = 10;

  localparam logic [PTN_W-1:0] PTN_COLORBAR = 3'd0;
  localparam logic [PTN_W-1:0] PTN_GRAY     = 3'd1;
  localparam logic [PTN_W-1:0] PTN_GRID     = 3'd2;
  localparam logic [PTN_W-1:0] PTN_SOLID    = 3'd3;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HOLD = 1'b1
  } ptn_state_e;

endpackage

// File: rtl/ptn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stable-level debouncer and
// rising-edge press pulse. Release never produces a pulse.
module ptn_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 250000
) (
  input  logic PCK,
  input  logic RST,
  input  logic BTN_IN,
  output logic LEVEL,
  output logic PRESS
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYC + 1);

  logic            sync_1;
  logic            sync_2;
  logic            level_d;
  logic [DB_W-1:0] db_cnt;

  // Synchronize, require DEBOUNCE_CYC consecutive differing samples to flip, then edge-detect.
  always_ff @(posedge PCK) begin
    if (RST) begin
      sync_1  <= 1'b0;
      sync_2  <= 1'b0;
      LEVEL   <= 1'b0;
      level_d <= 1'b0;
      db_cnt  <= '0;
      PRESS   <= 1'b0;
    end else begin
      sync_1  <= BTN_IN;
      sync_2  <= sync_1;
      level_d <= LEVEL;
      PRESS   <= LEVEL & ~level_d;
      if (sync_2 != LEVEL) begin
        if (db_cnt == DB_W'(DEBOUNCE_CYC - 1)) begin
          LEVEL  <= sync_2;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ptn_sequencer.sv
// Frame-synchronous test-pattern scheduler: auto-cycles patterns every
// DWELL_FRAMES frames in RUN, advances on BTN_NEXT, toggles RUN/HOLD on
// BTN_MODE. Pattern changes only take effect at the frame boundary.
module ptn_sequencer
  import ptn_pkg::*;
#(
  parameter int unsigned NUM_PTN         = NUM_PTN_DEF,
  parameter int unsigned DWELL_FRAMES    = 120,
  parameter int unsigned DEBOUNCE_CYC    = 250000,
  parameter int unsigned H_SYNC_INTERVAL = 800,
  parameter int unsigned V_SYNC_INTERVAL = 525
) (
  input  logic             PCK,
  input  logic             RST,
  input  logic [CNT_W-1:0] VCNT,
  input  logic [CNT_W-1:0] HCNT,
  input  logic             BTN_NEXT,
  input  logic             BTN_MODE,
  output logic [PTN_W-1:0] PTN_SEL,
  output logic             PTN_UPD,
  output logic             HOLD
);

  localparam int unsigned DW_W = $clog2(DWELL_FRAMES);

  ptn_state_e       state;
  ptn_state_e       state_nxt;
  logic             pending;
  logic             pending_nxt;
  logic [DW_W-1:0]  dwell_cnt;
  logic [DW_W-1:0]  dwell_nxt;
  logic [PTN_W-1:0] sel_nxt;
  logic             upd_nxt;
  logic             advance;
  logic             fb;
  logic             next_press;
  logic             mode_press;
  logic             next_level_unused;
  logic             mode_level_unused;

  ptn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_next (
    .PCK    (PCK),
    .RST    (RST),
    .BTN_IN (BTN_NEXT),
    .LEVEL  (next_level_unused),
    .PRESS  (next_press)
  );

  ptn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_mode (
    .PCK    (PCK),
    .RST    (RST),
    .BTN_IN (BTN_MODE),
    .LEVEL  (mode_level_unused),
    .PRESS  (mode_press)
  );

  // Last pixel of the frame: the only point where the pattern may change.
  assign fb = (HCNT == CNT_W'(H_SYNC_INTERVAL - 1)) && (VCNT == CNT_W'(V_SYNC_INTERVAL - 1));

  // Next-state and next-output logic; frame evaluation uses the pre-toggle state.
  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    dwell_nxt   = dwell_cnt;
    sel_nxt     = PTN_SEL;
    upd_nxt     = 1'b0;
    advance     = 1'b0;

    if (fb) begin
      advance     = pending | next_press |
                    ((state == S_RUN) && (dwell_cnt == DW_W'(DWELL_FRAMES - 1)));
      pending_nxt = 1'b0;
      if (advance) begin
        sel_nxt   = (PTN_SEL == PTN_W'(NUM_PTN - 1)) ? '0 : PTN_SEL + PTN_W'(1);
        upd_nxt   = 1'b1;
        dwell_nxt = '0;
      end else if (state == S_RUN) begin
        dwell_nxt = dwell_cnt + DW_W'(1);
      end
    end else if (next_press) begin
      pending_nxt = 1'b1;
    end

    if (mode_press) begin
      if (state == S_RUN) begin
        state_nxt = S_HOLD;
      end else begin
        state_nxt = S_RUN;
        dwell_nxt = '0;
      end
    end
  end

  // State, request, dwell and output registers.
  always_ff @(posedge PCK) begin
    if (RST) begin
      state     <= S_RUN;
      pending   <= 1'b0;
      dwell_cnt <= '0;
      PTN_SEL   <= PTN_COLORBAR;
      PTN_UPD   <= 1'b0;
      HOLD      <= 1'b0;
    end else begin
      state     <= state_nxt;
      pending   <= pending_nxt;
      dwell_cnt <= dwell_nxt;
      PTN_SEL   <= sel_nxt;
      PTN_UPD   <= upd_nxt;
      HOLD      <= (state_nxt == S_HOLD);
    end
  end

endmodule
